// File: rtl/wolfram_ca_engine_if.sv
// wolfram_ca_engine_if: host-side control/status bundle for the cellular-automaton engine
interface wolfram_ca_engine_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 8
);
  logic              rule_we;
  logic [7:0]        rule_in;
  logic              load;
  logic [WIDTH-1:0]  seed;
  logic              wrap;
  logic              start;
  logic [STEP_W-1:0] steps;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  cells;
  logic [STEP_W-1:0] gen_count;
  modport master (
    output rule_we, rule_in, load, seed, wrap, start, steps,
    input  busy, done, cells, gen_count
  );
  modport slave (
    input  rule_we, rule_in, load, seed, wrap, start, steps,
    output busy, done, cells, gen_count
  );
endinterface

// File: rtl/wolfram_ca_engine.sv
// wolfram_ca_engine: elementary CA row stepped under a programmable 8-bit rule with start/busy/done runs
module wolfram_ca_engine #(
  parameter int         WIDTH        = 16,
  parameter int         STEP_W       = 8,
  parameter logic [7:0] DEFAULT_RULE = 8'hD2
) (
  input logic               clk,
  input logic               rst,
  wolfram_ca_engine_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state, state_nx;
  logic [7:0]        rule;
  logic [WIDTH-1:0]  cells, nxt;
  logic [WIDTH+1:0]  ext;
  logic [STEP_W-1:0] gen, rem;
  logic              wrap_q, done, done_nx, go, zero_go, last;
  assign go      = state == IDLE && !bus.load && bus.start && bus.steps != '0;
  assign zero_go = state == IDLE && !bus.load && bus.start && bus.steps == '0;
  assign last    = state == RUN && !bus.load && rem == STEP_W'(1);
  // Row extended by one neighbour on each side; outside cells read 0 unless the run wraps.
  assign ext = {wrap_q & cells[0], cells, wrap_q & cells[WIDTH-1]};
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign nxt[i] = rule[3'd7 - ext[i+2:i]];
  end
  // Next state: IDLE->RUN on a nonzero start, RUN->IDLE on the final step or an aborting load.
  always_comb begin
    state_nx = state;
    done_nx  = zero_go || last;
    if (state == IDLE) state_nx = go ? RUN : IDLE;
    else               state_nx = (bus.load || rem == STEP_W'(1)) ? IDLE : RUN;
  end
  // State, row, counters and rule register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      rule   <= DEFAULT_RULE;
      cells  <= '0;
      gen    <= '0;
      rem    <= '0;
      wrap_q <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (bus.load) begin
        cells <= bus.seed;
        gen   <= '0;
      end else if (state == RUN) begin
        cells <= nxt;
        gen   <= gen + STEP_W'(1);
        rem   <= rem - STEP_W'(1);
      end else if (go) begin
        rem    <= bus.steps;
        wrap_q <= bus.wrap;
      end
      if (state == IDLE && bus.rule_we) rule <= bus.rule_in;
    end
  end
  assign bus.busy      = state == RUN;
  assign bus.done      = done;
  assign bus.cells     = cells;
  assign bus.gen_count = gen;
endmodule

// File: tb/tb_wolfram_ca_engine.sv
// tb_wolfram_ca_engine: table vectors, corner sequences and random runs against a row-level CA model
module tb_wolfram_ca_engine;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [W-1:0] m_cells;
  logic [7:0]   m_gen;
  logic [7:0]   m_rule;
  typedef struct {
    bit         ld;
    bit         we;
    logic [7:0] rule;
    logic [7:0] seed;
    bit         wrap;
    logic [7:0] steps;
    logic [7:0] exp_cells;
    logic [7:0] exp_gen;
  } vec_t;
  vec_t tbl[5];
  wolfram_ca_engine_if #(.WIDTH(W), .STEP_W(8)) bus ();
  wolfram_ca_engine #(.WIDTH(W), .STEP_W(8), .DEFAULT_RULE(8'hD2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [W-1:0] ca_step(input logic [W-1:0] row, input logic [7:0] r, input bit w);
    logic [W-1:0] n;
    int l, c, rr, idx;
    for (int i = 0; i < W; i++) begin
      c   = int'(row[i]);
      l   = (i == W-1 && !w) ? 0 : int'(row[(i+1)%W]);
      rr  = (i == 0 && !w) ? 0 : int'(row[(i+W-1)%W]);
      idx = 4*l + 2*c + rr;
      n[i] = r[7-idx];
    end
    return n;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_run(input bit ld, input bit we, input logic [7:0] r, input logic [7:0] s,
                        input bit w, input logic [7:0] n);
    if (ld) begin
      bus.load = 1'b1;
      bus.seed = s;
      step();
      bus.load = 1'b0;
      m_cells = s;
      m_gen = 8'd0;
      chk("load_cells", 32'(bus.cells), 32'(m_cells));
      chk("load_gen", 32'(bus.gen_count), 32'(m_gen));
    end
    bus.start = 1'b1;
    bus.steps = n;
    bus.wrap = w;
    bus.rule_we = we;
    bus.rule_in = r;
    if (we) m_rule = r;
    step();
    bus.start = 1'b0;
    bus.rule_we = 1'b0;
    for (int k = 0; k < int'(n); k++) begin
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_done", 32'(bus.done), 32'd0);
      step();
      m_cells = ca_step(m_cells, m_rule, w);
      m_gen++;
      chk("run_cells", 32'(bus.cells), 32'(m_cells));
    end
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_done", 32'(bus.done), 32'd1);
    chk("end_cells", 32'(bus.cells), 32'(m_cells));
    chk("end_gen", 32'(bus.gen_count), 32'(m_gen));
    step();
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'hD2, 8'h10, 1'b1, 8'd1, 8'hE7, 8'd1};
    tbl[1] = '{1'b1, 1'b1, 8'hD2, 8'h01, 1'b1, 8'd1, 8'h7E, 8'd1};
    tbl[2] = '{1'b1, 1'b0, 8'hD2, 8'h01, 1'b0, 8'd1, 8'hFE, 8'd1};
    tbl[3] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'd3, 8'hFF, 8'd3};
    tbl[4] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 8'd0, 8'hFF, 8'd3};
    rst = 1'b1;
    bus.rule_we = 1'b0;
    bus.rule_in = 8'h00;
    bus.load = 1'b0;
    bus.seed = '0;
    bus.wrap = 1'b0;
    bus.start = 1'b0;
    bus.steps = 8'd0;
    m_cells = '0;
    m_gen = 8'd0;
    m_rule = 8'hD2;
    step();
    step();
    chk("rst_cells", 32'(bus.cells), 32'd0);
    chk("rst_gen", 32'(bus.gen_count), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    step();
    foreach (tbl[v]) begin
      do_run(tbl[v].ld, tbl[v].we, tbl[v].rule, tbl[v].seed, tbl[v].wrap, tbl[v].steps);
      chk("tbl_cells", 32'(bus.cells), 32'(tbl[v].exp_cells));
      chk("tbl_gen", 32'(bus.gen_count), 32'(tbl[v].exp_gen));
    end
    bus.load = 1'b1;
    bus.seed = 8'h5A;
    step();
    bus.load = 1'b0;
    m_cells = 8'h5A;
    m_gen = 8'd0;
    bus.start = 1'b1;
    bus.steps = 8'd10;
    bus.wrap = 1'b1;
    bus.rule_we = 1'b1;
    bus.rule_in = 8'hD2;
    m_rule = 8'hD2;
    step();
    bus.start = 1'b0;
    bus.rule_we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      m_cells = ca_step(m_cells, m_rule, 1'b1);
      m_gen++;
      chk("busy_cells", 32'(bus.cells), 32'(m_cells));
      chk("busy_gen", 32'(bus.gen_count), 32'(m_gen));
      chk("busy_high", 32'(bus.busy), 32'd1);
      bus.rule_we = (k == 2);
      bus.start = (k == 2);
      bus.rule_in = 8'h00;
      bus.steps = 8'd3;
      bus.wrap = (k == 2) ? 1'b0 : 1'b1;
    end
    bus.load = 1'b1;
    bus.seed = 8'hAA;
    step();
    bus.load = 1'b0;
    m_cells = 8'hAA;
    m_gen = 8'd0;
    chk("abort_cells", 32'(bus.cells), 32'h AA);
    chk("abort_gen", 32'(bus.gen_count), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    step();
    chk("abort_nodone", 32'(bus.done), 32'd0);
    do_run(1'b1, 1'b0, 8'h00, 8'h10, 1'b1, 8'd1);
    chk("rule_kept", 32'(bus.cells), 32'hE7);
    bus.load = 1'b1;
    bus.seed = 8'h3C;
    step();
    bus.load = 1'b0;
    bus.start = 1'b1;
    bus.steps = 8'd10;
    bus.rule_we = 1'b1;
    bus.rule_in = 8'hFF;
    step();
    bus.start = 1'b0;
    bus.rule_we = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_cells", 32'(bus.cells), 32'd0);
    chk("arst_gen", 32'(bus.gen_count), 32'd0);
    step();
    rst = 1'b0;
    m_cells = '0;
    m_gen = 8'd0;
    m_rule = 8'hD2;
    do_run(1'b1, 1'b0, 8'h00, 8'h10, 1'b1, 8'd1);
    chk("arst_default_rule", 32'(bus.cells), 32'hE7);
    for (int t = 0; t < 30; t++)
      do_run(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom_range(0, 12)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wolfram_ca_engine.md
# wolfram_ca_engine

Parametrised elementary cellular-automaton engine, the sequential successor to the fixed single-rule 3-input truth-table gates. It holds a WIDTH-cell row, applies a run-time programmable 8-bit Wolfram rule to every cell in parallel once per clock, and runs a requested number of generations under a start/busy/done handshake. The rule defaults to 0xD2 and can be reprogrammed. Either periodic (ring) or zero-padded boundaries can be selected. It sits between the host register interface and the downstream gate-assignment logic as a rule-evaluation workload generator.

## Interface
- WIDTH, 16: number of cells; must be >= 3.
- STEP_W, 8: width of the step request and generation counter.
- DEFAULT_RULE, 8'hD2: rule loaded at reset.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rule_we  in  1  write rule_in into the rule register (IDLE only).
- rule_in  in  8  new rule value.
- load  in  1  write seed into the cell row; clears gen_count.
- seed  in  WIDTH  initial row.
- wrap  in  1  boundary mode: 1 = periodic, 0 = cells outside the row read as 0; sampled at start.
- start  in  1  begin a run of `steps` generations (IDLE only).
- steps  in  STEP_W  generation count; sampled at start.
- busy  out  1  high while RUN.
- done  out  1  one-cycle pulse at run completion.
- cells  out  WIDTH  current row, registered.
- gen_count  out  STEP_W  generations computed since last load; wraps modulo 2^STEP_W.

## Operation
- Rule indexing matches the existing gate library:
  - next[i] = rule[7 - {L,C,R}], where L = cells[i+1], C = cells[i], R = cells[i-1].
  - Index 000 selects rule bit 7; index 111 selects bit 0.
- Boundaries:
  - wrap=1: cells[WIDTH] is cells[0] and cells[-1] is cells[WIDTH-1].
  - wrap=0: both read as 0.
- FSM has two states, IDLE and RUN.
- IDLE, in priority order:
  1. load: cells <= seed, gen_count <= 0; a start in the same cycle is ignored.
  2. start with steps == 0: done pulses next cycle; cells and gen_count unchanged; FSM stays IDLE.
  3. start with steps = N > 0: latch N into a remaining counter, latch wrap, go to RUN.
  4. rule_we: rule <= rule_in. It may coincide with start; the new rule is used for that run.
- RUN, every cycle:
  - cells <= next, gen_count += 1, remaining -= 1.
  - When remaining is 1 on that edge: go to IDLE and assert done.
- RUN, ignored inputs: start, rule_we and wrap changes.
- RUN, load aborts the run: cells <= seed, gen_count <= 0, go to IDLE, no done pulse.
- Reset (any time, including mid-run): IDLE, cells = 0, rule = DEFAULT_RULE, gen_count = 0, busy = 0, done = 0.

## Timing
- start sampled at edge T with steps = N > 0:
  - busy high from after edge T to after edge T+N, i.e. exactly N cycles.
  - cells update at edges T+1 through T+N.
  - done is high for the single cycle after edge T+N, with busy = 0.
- steps == 0: done high for the cycle after edge T; busy never rises.
- Throughput: a new start is accepted in the cycle done is high, giving back-to-back runs with one IDLE cycle between them.
- cells and gen_count are registered and change only at the edges listed above.
- Combinational next-state logic depth is one 8:1 mux per cell, independent of WIDTH.

## Test plan
- Reset: assert rst asynchronously mid-RUN -> busy = 0, done = 0, cells = 0, gen_count = 0 immediately. A run with rule_in unwritten uses 0xD2.
- WIDTH=8, rule 0xD2, load seed 8'h10, wrap=1, start steps=1:
  - cells = 8'hE7 one edge after start.
  - done pulses in the following cycle; gen_count = 1.
- WIDTH=8, rule 0xD2, seed 8'h01, steps=1:
  - wrap=1 -> cells = 8'h7E.
  - reload seed, wrap=0 -> cells = 8'hFE.
- rule_we 0xFF, seed 0, steps=3:
  - busy exactly 3 cycles, cells = 8'hFF, gen_count = 3, a single done pulse.
  - Then steps=0 -> done pulses next cycle; cells and gen_count unchanged.
- Busy-time inputs: start steps=10; at cycle 2 assert rule_we (0x00) and start -> both ignored, rule unchanged.
- Abort: at cycle 4 assert load with seed 8'hAA -> cells = 8'hAA, gen_count = 0, busy drops, no done pulse.
